// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the system-ID check master.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_ID,
    ST_RSP_ID,
    ST_REQ_TS,
    ST_RSP_TS,
    ST_EVAL,
    ST_FIN
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef struct packed {
    logic pass;
    logic id_mismatch;
    logic ts_mismatch;
    logic timeout;
  } result_flags_t;

endpackage

// File: rtl/sysid_check_timer.sv
// Loadable saturating cycle counter; expired when it sits at the limit, last one count earlier.
module sysid_check_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic inc,
  output logic expired,
  output logic last
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIMIT_M1 = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (inc && !expired) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LIMIT);
  assign last    = (count_q == LIMIT_M1);

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master: fetches system ID and build timestamp, compares them, reports sticky results.
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0100_0001,
  parameter logic [31:0] EXPECTED_TS    = 32'h5820_A5A2,
  parameter logic        CHECK_TS       = 1'b1,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_e        state_q, state_d;
  logic          read_q, read_d;
  logic          addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  result_flags_t flags_q, flags_d;
  logic [31:0]   id_q, id_d;
  logic [31:0]   ts_q, ts_d;
  logic          tmr_load, tmr_inc, tmr_expired, tmr_last;

  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    addr_d  = addr_q;
    flags_d = flags_q;
    id_d    = id_q;
    ts_d    = ts_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ_ID;
          read_d  = 1'b1;
          addr_d  = ADDR_ID;
          flags_d = '0;
          id_d    = '0;
          ts_d    = '0;
        end
      end
      ST_REQ_ID, ST_REQ_TS: begin
        if (read_q && !avm_waitrequest) begin
          read_d = 1'b0;
          // Zero-latency slave: data arrives with acceptance, so RSP is skipped.
          if (avm_readdatavalid && state_q == ST_REQ_ID) begin
            id_d    = avm_readdata;
            state_d = ST_REQ_TS;
            read_d  = 1'b1;
            addr_d  = ADDR_TS;
          end else if (avm_readdatavalid) begin
            ts_d    = avm_readdata;
            state_d = ST_EVAL;
          end else begin
            state_d = (state_q == ST_REQ_ID) ? ST_RSP_ID : ST_RSP_TS;
          end
        end else if (tmr_expired) begin
          read_d          = 1'b0;
          flags_d.timeout = 1'b1;
          state_d         = ST_FIN;
        end else if (tmr_last) begin
          read_d = 1'b0;
        end
      end
      ST_RSP_ID: begin
        if (avm_readdatavalid) begin
          id_d    = avm_readdata;
          state_d = ST_REQ_TS;
          read_d  = 1'b1;
          addr_d  = ADDR_TS;
        end else if (tmr_expired) begin
          flags_d.timeout = 1'b1;
          state_d         = ST_FIN;
        end
      end
      ST_RSP_TS: begin
        if (avm_readdatavalid) begin
          ts_d    = avm_readdata;
          state_d = ST_EVAL;
        end else if (tmr_expired) begin
          flags_d.timeout = 1'b1;
          state_d         = ST_FIN;
        end
      end
      ST_EVAL: begin
        flags_d.id_mismatch = (id_q != EXPECTED_ID);
        flags_d.ts_mismatch = (ts_q != EXPECTED_TS);
        flags_d.pass = (id_q == EXPECTED_ID) && !(CHECK_TS && (ts_q != EXPECTED_TS));
        state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // The per-word window restarts whenever a request phase is entered.
  assign tmr_load = (state_d != state_q) && (state_d == ST_REQ_ID || state_d == ST_REQ_TS);
  assign tmr_inc  = (state_q == ST_REQ_ID) || (state_q == ST_RSP_ID) ||
                    (state_q == ST_REQ_TS) || (state_q == ST_RSP_TS);

  sysid_check_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (tmr_load),
    .inc    (tmr_inc),
    .expired(tmr_expired),
    .last   (tmr_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= '0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      flags_q <= flags_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = flags_q.pass;
  assign id_mismatch = flags_q.id_mismatch;
  assign ts_mismatch = flags_q.ts_mismatch;
  assign timeout     = flags_q.timeout;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Three check masters (default, short timeout, timestamp-not-checked) against modelled Avalon slaves.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'h0100_0001;
  localparam logic [31:0] EXP_TS = 32'h5820_A5A2;
  localparam int N = 3;
  localparam int WINDOW = 60;
  localparam int STRAY_AT = 50;

  typedef struct {
    int          done_at;
    logic [3:0]  flags;
    logic [31:0] id_v;
    logic [31:0] ts_v;
  } expect_t;

  logic clock = 1'b0;
  logic reset, start, stray;
  logic [31:0] word0, word1;
  int wait_id, wait_ts, lat;
  int checks = 0;
  int failures = 0;

  logic        avm_read[N], avm_address[N], avm_waitrequest[N], avm_readdatavalid[N];
  logic [31:0] avm_readdata[N];
  logic        busy[N], done[N], pass[N], id_mismatch[N], ts_mismatch[N], timeout[N];
  logic [31:0] id_value[N], ts_value[N];

  always #5 clock = ~clock;

  sysid_check_master #(.TIMEOUT_CYCLES(255), .CHECK_TS(1'b1)) u_dut0 (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address[0]), .avm_read(avm_read[0]), .avm_waitrequest(avm_waitrequest[0]),
    .avm_readdata(avm_readdata[0]), .avm_readdatavalid(avm_readdatavalid[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .id_mismatch(id_mismatch[0]),
    .ts_mismatch(ts_mismatch[0]), .timeout(timeout[0]), .id_value(id_value[0]), .ts_value(ts_value[0])
  );

  sysid_check_master #(.TIMEOUT_CYCLES(8), .CHECK_TS(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address[1]), .avm_read(avm_read[1]), .avm_waitrequest(avm_waitrequest[1]),
    .avm_readdata(avm_readdata[1]), .avm_readdatavalid(avm_readdatavalid[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .id_mismatch(id_mismatch[1]),
    .ts_mismatch(ts_mismatch[1]), .timeout(timeout[1]), .id_value(id_value[1]), .ts_value(ts_value[1])
  );

  sysid_check_master #(.TIMEOUT_CYCLES(255), .CHECK_TS(1'b0)) u_dut2 (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address[2]), .avm_read(avm_read[2]), .avm_waitrequest(avm_waitrequest[2]),
    .avm_readdata(avm_readdata[2]), .avm_readdatavalid(avm_readdatavalid[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .id_mismatch(id_mismatch[2]),
    .ts_mismatch(ts_mismatch[2]), .timeout(timeout[2]), .id_value(id_value[2]), .ts_value(ts_value[2])
  );

  // Slave: stalls wait_id/wait_ts cycles per read, then answers after lat cycles (0 = same cycle).
  for (genvar g = 0; g < N; g++) begin : g_slave
    int   wcnt;
    int   pcnt;
    logic paddr;
    logic zero_accept;

    always @(posedge clock or posedge reset) begin
      if (reset) begin
        wcnt  <= 0;
        pcnt  <= 0;
        paddr <= 1'b0;
      end else begin
        wcnt <= (avm_read[g] && avm_waitrequest[g]) ? wcnt + 1 : 0;
        if (avm_read[g] && !avm_waitrequest[g] && lat > 0) begin
          pcnt  <= lat;
          paddr <= avm_address[g];
        end else if (pcnt > 0) begin
          pcnt <= pcnt - 1;
        end
      end
    end

    assign avm_waitrequest[g] = avm_read[g] && (wcnt < (avm_address[g] ? wait_ts : wait_id));
    assign zero_accept = avm_read[g] && !avm_waitrequest[g] && (lat == 0);
    assign avm_readdatavalid[g] = stray || (pcnt == 1) || zero_accept;
    assign avm_readdata[g] = (pcnt == 1) ? (paddr ? word1 : word0) :
                             zero_accept ? (avm_address[g] ? word1 : word0) : 32'hDEAD_BEEF;
  end

  function automatic int tmo_of(input int i);
    return (i == 1) ? 8 : 255;
  endfunction

  function automatic bit chk_of(input int i);
    return (i != 2);
  endfunction

  // A word succeeds if accepted before the window closes and its data lands no later than the limit.
  function automatic expect_t predict(input logic [31:0] w0, input logic [31:0] w1, input int wid,
                                      input int wts, input int lt, input int tmo, input bit chk);
    expect_t e;
    bit idm, tsm;
    e.flags = 4'b0000;
    e.id_v = '0;
    e.ts_v = '0;
    if (wid >= tmo || wid + lt > tmo) begin
      e.flags = 4'b0001;
      e.done_at = tmo + 2;
      return e;
    end
    e.id_v = w0;
    if (wts >= tmo || wts + lt > tmo) begin
      e.flags = 4'b0001;
      e.done_at = (wid + 1 + lt) + tmo + 2;
      return e;
    end
    e.ts_v = w1;
    idm = (w0 != EXP_ID);
    tsm = (w1 != EXP_TS);
    e.flags = {!idm && !(chk && tsm), idm, tsm, 1'b0};
    e.done_at = (wid + 1 + lt) + (wts + 1 + lt) + 2;
    return e;
  endfunction

  function automatic logic [127:0] all_outputs(input int i);
    return {56'b0, avm_read[i], avm_address[i], busy[i], done[i], pass[i], id_mismatch[i],
            ts_mismatch[i], timeout[i], id_value[i], ts_value[i]};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                               input int wid, input int wts, input int lt,
                               input bit restart, input bit check_drop);
    int done_at[N];
    int done_cnt[N];
    logic busy_first[N];
    logic busy_after[N];
    logic read_b8, read_b9, prev_stall, prev_addr;
    bit stable;
    expect_t e;
    word0 = w0;
    word1 = w1;
    wait_id = wid;
    wait_ts = wts;
    lat = lt;
    stable = 1'b1;
    prev_stall = 1'b0;
    prev_addr = 1'b0;
    read_b8 = 1'b0;
    read_b9 = 1'b0;
    for (int i = 0; i < N; i++) begin
      done_at[i] = 0;
      done_cnt[i] = 0;
      busy_first[i] = 1'b0;
      busy_after[i] = 1'b1;
    end
    @(negedge clock);
    start = 1'b1;
    for (int k = 1; k <= WINDOW; k++) begin
      @(negedge clock);
      start = restart && (k == 3);
      stray = (k == STRAY_AT);
      if (k == 8) read_b8 = avm_read[1];
      if (k == 9) read_b9 = avm_read[1];
      if (prev_stall && (avm_read[0] !== 1'b1 || avm_address[0] !== prev_addr)) stable = 1'b0;
      prev_stall = avm_read[0] && avm_waitrequest[0];
      prev_addr = avm_address[0];
      for (int i = 0; i < N; i++) begin
        if (k == 1) busy_first[i] = busy[i];
        if (done_at[i] != 0 && k == done_at[i] + 1) busy_after[i] = busy[i];
        if (done[i]) begin
          done_cnt[i]++;
          if (done_at[i] == 0) done_at[i] = k;
        end
      end
    end
    stray = 1'b0;
    for (int i = 0; i < N; i++) begin
      e = predict(w0, w1, wid, wts, lt, tmo_of(i), chk_of(i));
      checkOutput($sformatf("%s.u%0d.done_cycle", tag, i), done_at[i], e.done_at);
      checkOutput($sformatf("%s.u%0d.done_count", tag, i), done_cnt[i], 1);
      checkOutput($sformatf("%s.u%0d.flags", tag, i),
                  {pass[i], id_mismatch[i], ts_mismatch[i], timeout[i]}, e.flags);
      checkOutput($sformatf("%s.u%0d.id_value", tag, i), id_value[i], e.id_v);
      checkOutput($sformatf("%s.u%0d.ts_value", tag, i), ts_value[i], e.ts_v);
      checkOutput($sformatf("%s.u%0d.busy_start", tag, i), busy_first[i], 1'b1);
      checkOutput($sformatf("%s.u%0d.busy_end", tag, i), busy_after[i], 1'b0);
    end
    if (wid > 0) checkOutput($sformatf("%s.u0.stall_stable", tag), stable, 1'b1);
    if (check_drop) begin
      checkOutput($sformatf("%s.u1.read_cycle8", tag), read_b8, 1'b1);
      checkOutput($sformatf("%s.u1.read_cycle9", tag), read_b9, 1'b0);
    end
  endtask

  task automatic applyResetMidRead();
    int done_seen;
    done_seen = 0;
    word0 = EXP_ID;
    word1 = EXP_TS;
    wait_id = 0;
    wait_ts = 0;
    lat = 1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < N; i++) checkOutput($sformatf("rst_mid.u%0d.during", i), all_outputs(i), '0);
    reset = 1'b0;
    stray = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      stray = 1'b0;
      for (int i = 0; i < N; i++) if (done[i]) done_seen++;
    end
    checkOutput("rst_mid.no_done", done_seen, 0);
    for (int i = 0; i < N; i++) checkOutput($sformatf("rst_mid.u%0d.after", i), all_outputs(i), '0);
  endtask

  initial begin
    logic [31:0] w0, w1;
    reset = 1'b1;
    start = 1'b0;
    stray = 1'b0;
    word0 = EXP_ID;
    word1 = EXP_TS;
    wait_id = 0;
    wait_ts = 0;
    lat = 1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < N; i++) checkOutput($sformatf("reset.u%0d.outputs", i), all_outputs(i), '0);
    reset = 1'b0;

    applyStimulus("match", EXP_ID, EXP_TS, 0, 0, 1, 1'b0, 1'b0);
    applyStimulus("id_bad", 32'h0100_0002, EXP_TS, 0, 0, 1, 1'b0, 1'b0);
    applyStimulus("ts_zero", EXP_ID, 32'h0, 0, 0, 1, 1'b0, 1'b0);
    applyStimulus("id_stall10", EXP_ID, EXP_TS, 10, 0, 1, 1'b0, 1'b1);
    applyStimulus("restart", EXP_ID, EXP_TS, 0, 0, 1, 1'b1, 1'b0);
    applyResetMidRead();
    applyStimulus("after_reset", EXP_ID, EXP_TS, 0, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      w0 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
      w1 = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      applyStimulus($sformatf("rand%0d", n), w0, w1, $urandom_range(0, 12), $urandom_range(0, 12),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
